// File: rtl/bcmp_pkg.sv
// rtl/bcmp_pkg.sv - shared funct3 codes, stage control struct and branch decode
//
// Purpose : definitions shared by branch_cmp_pipe and its bench-facing users.
// Contents: F3_* branch funct3 codes, bcmp_stage_t per-stage control record,
//           bcmp_decode() mapping {funct3, eq, lt, ltu} to {illegal, taken}.
package bcmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Control half of a stage register. The XLEN-wide partial difference and
  // the operand bits still to be processed travel alongside in arrays sized
  // by the module parameters, since a package cannot see those.
  typedef struct packed {
    logic       valid;
    logic [2:0] funct3;
    logic       carry;   // carry-out of the most recently processed segment
    logic       zero;    // every diff bit produced so far is zero
    logic       msb_a;   // Rs1[XLEN-1]
    logic       msb_b;   // Rs2[XLEN-1]
  } bcmp_stage_t;

  // Returns {illegal, taken}.
  function automatic logic [1:0] bcmp_decode(input logic [2:0] f3,
                                             input logic       eq,
                                             input logic       lt,
                                             input logic       ltu);
    logic [1:0] res;
    res = 2'b10;
    case (f3)
      F3_BEQ:  res = {1'b0, eq};
      F3_BNE:  res = {1'b0, ~eq};
      F3_BLT:  res = {1'b0, lt};
      F3_BGE:  res = {1'b0, ~lt};
      F3_BLTU: res = {1'b0, ltu};
      F3_BGEU: res = {1'b0, ~ltu};
      default: res = 2'b10;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg_cla.sv
// rtl/seg_cla.sv - W-bit generate/propagate carry-lookahead adder segment
//
// Ports: i_a, i_b  W-bit addends
//        i_cin     carry in
//        o_sum     W-bit sum
//        o_cout    carry out of bit W-1
module seg_cla #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W:0]   w_c;
  logic         w_term;
  logic         w_acc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is the flat sum-of-products of generate terms and the carry-in,
  // so no carry depends on the previous one (no ripple chain).
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_acc  = 1'b0;
    w_c[0] = i_cin;
    for (int k = 0; k < W; k++) begin
      w_term = i_cin;
      for (int j = 0; j <= k; j++) w_term = w_term & w_p[j];
      w_acc = w_term;
      for (int j = 0; j <= k; j++) begin
        w_term = w_g[j];
        for (int m = j + 1; m <= k; m++) w_term = w_term & w_p[m];
        w_acc = w_acc | w_term;
      end
      w_c[k+1] = w_acc;
    end
  end

  assign o_sum  = w_p ^ w_c[W-1:0];
  assign o_cout = w_c[W];

endmodule

// File: rtl/branch_cmp_pipe.sv
// rtl/branch_cmp_pipe.sv - pipelined segmented-CLA branch comparator
//
// Computes Rs1 - Rs2 one SEGW-bit segment per stage and decodes the branch
// condition for funct3 at the last stage. Optional macro BCMP_SKID_EN adds a
// one-entry output skid so in_ready is registered.
//
// Ports: CLK, rst_n (async, active-low)
//        in_valid/in_ready, Rs1, Rs2, funct3   operation input handshake
//        flush                                 kill all in-flight operations
//        out_valid/out_ready, taken, illegal, diff   result handshake
module branch_cmp_pipe
  import bcmp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSEG = 4
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Rs2,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            illegal,
  output logic [XLEN-1:0] diff
);

  localparam int SEGW = XLEN / NSEG;

  bcmp_stage_t     r_ctl      [NSEG];
  logic [XLEN-1:0] r_diff     [NSEG];
  logic [XLEN-1:0] r_opa      [NSEG];
  logic [XLEN-1:0] r_opb      [NSEG];

  bcmp_stage_t     w_nxt_ctl  [NSEG];
  logic [XLEN-1:0] w_nxt_diff [NSEG];
  logic [XLEN-1:0] w_nxt_opa  [NSEG];
  logic [XLEN-1:0] w_nxt_opb  [NSEG];
  logic [SEGW-1:0] w_seg_a    [NSEG];
  logic [SEGW-1:0] w_seg_b    [NSEG];
  logic [SEGW-1:0] w_sum      [NSEG];
  logic            w_cin      [NSEG];
  logic            w_cout     [NSEG];

  logic            w_adv;
  logic            w_take;

  // Subtraction as Rs1 + ~Rs2 + 1: stage 0 injects the +1 as its carry-in,
  // later stages take the carry registered by the stage before.
  for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign w_seg_a[gi]    = Rs1[SEGW-1:0];
      assign w_seg_b[gi]    = ~Rs2[SEGW-1:0];
      assign w_cin[gi]      = 1'b1;
      assign w_nxt_opa[gi]  = Rs1;
      assign w_nxt_opb[gi]  = Rs2;
      assign w_nxt_diff[gi] = XLEN'(w_sum[gi]);
      assign w_nxt_ctl[gi]  = '{valid: w_take, funct3: funct3, carry: w_cout[gi],
                                zero: ~|w_sum[gi], msb_a: Rs1[XLEN-1],
                                msb_b: Rs2[XLEN-1]};
    end else begin : g_body
      assign w_seg_a[gi]    = r_opa[gi-1][gi*SEGW +: SEGW];
      assign w_seg_b[gi]    = ~r_opb[gi-1][gi*SEGW +: SEGW];
      assign w_cin[gi]      = r_ctl[gi-1].carry;
      assign w_nxt_opa[gi]  = r_opa[gi-1];
      assign w_nxt_opb[gi]  = r_opb[gi-1];
      // Bits above the processed segments are always zero, so OR-in is a merge.
      assign w_nxt_diff[gi] = r_diff[gi-1] | (XLEN'(w_sum[gi]) << (gi * SEGW));
      assign w_nxt_ctl[gi]  = '{valid: r_ctl[gi-1].valid, funct3: r_ctl[gi-1].funct3,
                                carry: w_cout[gi],
                                zero: r_ctl[gi-1].zero & ~|w_sum[gi],
                                msb_a: r_ctl[gi-1].msb_a, msb_b: r_ctl[gi-1].msb_b};
    end

    seg_cla #(.W(SEGW)) u_cla (
      .i_a    (w_seg_a[gi]),
      .i_b    (w_seg_b[gi]),
      .i_cin  (w_cin[gi]),
      .o_sum  (w_sum[gi]),
      .o_cout (w_cout[gi])
    );
  end

  // All stages move together; flush clears valids whether or not they move.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        r_ctl[i]  <= '0;
        r_diff[i] <= '0;
        r_opa[i]  <= '0;
        r_opb[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NSEG; i++) begin
        if (w_adv) begin
          r_ctl[i]  <= w_nxt_ctl[i];
          r_diff[i] <= w_nxt_diff[i];
          r_opa[i]  <= w_nxt_opa[i];
          r_opb[i]  <= w_nxt_opb[i];
        end
        if (flush) r_ctl[i].valid <= 1'b0;
      end
    end
  end

  bcmp_stage_t     w_last;
  logic [XLEN-1:0] w_last_diff;
  logic            w_lt;
  logic            w_ltu;
  logic            w_taken;
  logic            w_illegal;

  assign w_last      = r_ctl[NSEG-1];
  assign w_last_diff = r_diff[NSEG-1];
  // Signs differ: the negative operand is the smaller, and the diff sign may
  // have overflowed. Signs equal: the diff sign is exact.
  assign w_lt  = (w_last.msb_a != w_last.msb_b) ? w_last.msb_a : w_last_diff[XLEN-1];
  assign w_ltu = ~w_last.carry;
  assign {w_illegal, w_taken} = bcmp_decode(w_last.funct3, w_last.zero, w_lt, w_ltu);

`ifdef BCMP_SKID_EN
  logic            r_skid_full;
  logic            r_skid_taken;
  logic            r_skid_illegal;
  logic [XLEN-1:0] r_skid_diff;

  // The pipeline only moves while the skid is empty; a result stalled at the
  // last stage is parked in the skid on that move so nothing is overwritten.
  assign w_adv    = ~r_skid_full;
  assign in_ready = ~r_skid_full;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_full    <= 1'b0;
      r_skid_taken   <= 1'b0;
      r_skid_illegal <= 1'b0;
      r_skid_diff    <= '0;
    end else if (flush) begin
      r_skid_full <= 1'b0;
    end else if (r_skid_full) begin
      if (out_ready) r_skid_full <= 1'b0;
    end else if (w_last.valid && !out_ready) begin
      r_skid_full    <= 1'b1;
      r_skid_taken   <= w_taken;
      r_skid_illegal <= w_illegal;
      r_skid_diff    <= w_last_diff;
    end
  end

  assign out_valid = r_skid_full | w_last.valid;
  assign taken     = r_skid_full ? r_skid_taken   : w_taken;
  assign illegal   = r_skid_full ? r_skid_illegal : w_illegal;
  assign diff      = r_skid_full ? r_skid_diff    : w_last_diff;
`else
  assign w_adv     = ~(w_last.valid & ~out_ready);
  assign in_ready  = w_adv;
  assign out_valid = w_last.valid;
  assign taken     = w_taken;
  assign illegal   = w_illegal;
  assign diff      = w_last_diff;
`endif

  assign w_take = in_valid & in_ready;

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// tb/tb_branch_cmp_pipe.sv - directed self-checking bench for branch_cmp_pipe
module tb_branch_cmp_pipe;

  localparam int XLEN = 32;
  localparam int NSEG = 4;

  logic            CLK = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] Rs1;
  logic [XLEN-1:0] Rs2;
  logic [2:0]      funct3;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic            illegal;
  logic [XLEN-1:0] diff;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] s_a [8] = '{32'h0000_0010, 32'h1234_5678, 32'hFFFF_0000, 32'h0000_FFFF,
                           32'h8000_0001, 32'h7FFF_FFFF, 32'h0001_0000, 32'hDEAD_BEEF};
  logic [31:0] s_b [8] = '{32'h0000_0010, 32'h1234_5679, 32'h0000_FFFF, 32'hFFFF_0000,
                           32'h8000_0001, 32'h8000_0000, 32'h0000_FFFF, 32'hDEAD_BEEF};
  logic [2:0]  s_f [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b111};

  branch_cmp_pipe #(.XLEN(XLEN), .NSEG(NSEG)) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Rs1       (Rs1),
    .Rs2       (Rs2),
    .funct3    (funct3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .illegal   (illegal),
    .diff      (diff)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    logic r;
    r = 1'b0;
    case (f3)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = ($signed(a) <  $signed(b));
      3'b101:  r = ($signed(a) >= $signed(b));
      3'b110:  r = (a <  b);
      3'b111:  r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the pipeline idle and out_ready high.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic exp_taken,
                        input logic exp_illegal, input logic [31:0] exp_diff);
    int lat;
    Rs1 = a; Rs2 = b; funct3 = f3; in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(NSEG));
    chk({tag, ".taken"},   32'(taken),   32'(exp_taken));
    chk({tag, ".illegal"}, 32'(illegal), 32'(exp_illegal));
    chk({tag, ".diff"},    diff,         exp_diff);
    @(negedge CLK);
    chk({tag, ".drain"},   32'(out_valid), 32'd0);
  endtask

  initial begin
    int sent;
    int rcvd;
    int cyc;
    int lat;

    rst_n = 1'b0; in_valid = 1'b0; Rs1 = '0; Rs2 = '0; funct3 = 3'b000;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready",  32'(in_ready),  32'd1);
    chk("reset.taken",     32'(taken),     32'd0);
    chk("reset.illegal",   32'(illegal),   32'd0);
    chk("reset.diff",      diff,           32'd0);
    rst_n = 1'b1;
    @(negedge CLK);

    run_op("beq_eq",      32'd5,         32'd5,         3'b000, 1'b1, 1'b0, 32'h0000_0000);
    run_op("blt_neg",     32'hFFFF_FFFF, 32'd1,         3'b100, 1'b1, 1'b0, 32'hFFFF_FFFE);
    run_op("bltu_big",    32'hFFFF_FFFF, 32'd1,         3'b110, 1'b0, 1'b0, 32'hFFFF_FFFE);
    run_op("bge_ovf",     32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b0, 1'b0, 32'h0000_0001);
    run_op("bne_ne",      32'd7,         32'd9,         3'b001, 1'b1, 1'b0, 32'hFFFF_FFFE);
    run_op("bgeu_ge",     32'd9,         32'd7,         3'b111, 1'b1, 1'b0, 32'h0000_0002);
    run_op("illegal_010", 32'd3,         32'd3,         3'b010, 1'b0, 1'b1, 32'h0000_0000);
    run_op("illegal_011", 32'd4,         32'd1,         3'b011, 1'b0, 1'b1, 32'h0000_0003);

    // Back-to-back stream, consumer stalls on cycles 6..8.
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 8 && cyc < 60) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        Rs1 = s_a[sent]; Rs2 = s_b[sent]; funct3 = s_f[sent];
      end
      #1;
      if (!out_ready && rcvd < 8) begin
        chk($sformatf("stall%0d.valid", cyc), 32'(out_valid), 32'd1);
        chk($sformatf("stall%0d.diff", cyc),  diff, s_a[rcvd] - s_b[rcvd]);
      end
      if (out_valid && out_ready && rcvd < 8) begin
        chk($sformatf("stream%0d.diff", rcvd),  diff, s_a[rcvd] - s_b[rcvd]);
        chk($sformatf("stream%0d.taken", rcvd), 32'(taken),
            32'(ref_taken(s_f[rcvd], s_a[rcvd], s_b[rcvd])));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge CLK);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream.sent", 32'(sent), 32'd8);
    chk("stream.rcvd", 32'(rcvd), 32'd8);
    for (int k = 0; k < NSEG; k++) begin
      #1;
      chk($sformatf("stream.nodup%0d", k), 32'(out_valid), 32'd0);
      @(negedge CLK);
    end

    // Flush with three operations in flight and a fourth offered.
    for (int k = 0; k < 3; k++) begin
      Rs1 = 32'(k + 20); Rs2 = 32'd1; funct3 = 3'b001; in_valid = 1'b1;
      @(negedge CLK);
    end
    flush = 1'b1; Rs1 = 32'd99; in_valid = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      #1;
      chk($sformatf("flush.quiet%0d", k), 32'(out_valid), 32'd0);
      @(negedge CLK);
    end

    // Asynchronous reset while a result waits at the output and one follows.
    out_ready = 1'b0;
    Rs1 = 32'd50; Rs2 = 32'd8; funct3 = 3'b000; in_valid = 1'b1;
    @(negedge CLK);
    Rs1 = 32'd60;
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk("rst.pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    @(negedge CLK);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    run_op("post_rst", 32'd50, 32'd8, 3'b110, 1'b0, 1'b0, 32'h0000_002A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
